// File: rtl/clkdivs_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clkdivs_prog
//  Description : Runtime-programmable clock divider. Produces a registered
//                divided clock CLKOUT and a TICK strobe. The divisor reloads
//                through DIV_LD/DIV_ACK and only switches at a period boundary.
//                Define CLKDIVS_ODD_EN to allow odd divisors (low phase longer).
//  Revision    : 1.0 - initial release
// ============================================================================
module clkdivs_prog #(
    parameter int W       = 16,
    parameter int DEF_DIV = 16
) (
    input  logic         CLKIN,
    input  logic         ACLR_L,
    input  logic         EN,
    input  logic         DIV_LD,
    input  logic [W-1:0] DIV_IN,
    output logic         DIV_ACK,
    output logic         DIV_ERR,
    output logic         BUSY,
    output logic         CLKOUT,
    output logic         TICK
);

`ifdef CLKDIVS_ODD_EN
    localparam logic [W-1:0] c_def_div = W'(DEF_DIV);
`else
    localparam logic [W-1:0] c_def_div = W'(DEF_DIV) & ~W'(1);
`endif

    logic [W-1:0] r_d_act;
    logic [W-1:0] r_d_pend;
    logic         r_pend;
    logic [W-1:0] r_cnt;
    logic         r_clkout;
    logic         r_tick;
    logic         r_ack;
    logic         r_err;

    logic [W-1:0] w_din;
    logic         w_din_ok;
    logic [W-1:0] w_lm1;
    logic         w_wrap;
    logic         w_rise;
    logic         w_apply;

`ifdef CLKDIVS_ODD_EN
    assign w_din = DIV_IN;
`else
    assign w_din = {DIV_IN[W-1:1], 1'b0};
`endif

    assign w_din_ok = (DIV_IN >= W'(2));

    // Last low-phase count: L-1 with L = ceil(D/2), so odd divisors stay low longer
    assign w_lm1   = (r_d_act >> 1) - {{(W-1){1'b0}}, ~r_d_act[0]};
    assign w_wrap  = (r_cnt == r_d_act - 1'b1);
    assign w_rise  = (r_cnt == w_lm1);
    assign w_apply = r_pend && (!EN || w_wrap);

    always_ff @(posedge CLKIN or negedge ACLR_L) begin
        if (!ACLR_L) begin
            r_d_act  <= c_def_div;
            r_d_pend <= c_def_div;
            r_pend   <= 1'b0;
            r_cnt    <= '0;
            r_clkout <= 1'b0;
            r_tick   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
            r_err  <= DIV_LD && !w_din_ok;

            if (EN) begin
                if (w_wrap) begin
                    r_cnt    <= '0;
                    r_clkout <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_rise) begin
                    r_clkout <= 1'b1;
                    r_tick   <= 1'b1;
                end
            end

            // While frozen there is no boundary to wait for, so restart the period
            if (w_apply) begin
                r_d_act <= r_d_pend;
                r_ack   <= 1'b1;
                if (!EN) begin
                    r_cnt    <= '0;
                    r_clkout <= 1'b0;
                end
            end

            if (DIV_LD && w_din_ok) begin
                r_d_pend <= w_din;
                r_pend   <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign DIV_ACK = r_ack;
    assign DIV_ERR = r_err;
    assign BUSY    = r_pend;
    assign CLKOUT  = r_clkout;
    assign TICK    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clkdivs_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clkdivs_prog
//  Description : Directed self-checking bench for clkdivs_prog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdivs_prog;

    localparam int W = 16;

    logic         CLKIN;
    logic         ACLR_L;
    logic         EN;
    logic         DIV_LD;
    logic [W-1:0] DIV_IN;
    logic         DIV_ACK;
    logic         DIV_ERR;
    logic         BUSY;
    logic         CLKOUT;
    logic         TICK;

    int n_vec;
    int n_err;
    int ph;
    int dm;

    clkdivs_prog #(.W(W), .DEF_DIV(16)) u_dut (
        .CLKIN  (CLKIN),
        .ACLR_L (ACLR_L),
        .EN     (EN),
        .DIV_LD (DIV_LD),
        .DIV_IN (DIV_IN),
        .DIV_ACK(DIV_ACK),
        .DIV_ERR(DIV_ERR),
        .BUSY   (BUSY),
        .CLKOUT (CLKOUT),
        .TICK   (TICK)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge; the model counter ph advances like the divider and
    // CLKOUT/TICK are predicted from ph against L = ceil(dm/2).
    task automatic step(input logic e_err, input logic e_busy, input logic e_ack);
        int  l;
        logic e_clk;
        logic e_tick;
        @(posedge CLKIN);
        #1;
        l = dm - dm / 2;
        if (EN) ph = (ph == dm - 1) ? 0 : ph + 1;
        e_clk  = (ph >= l);
        e_tick = EN && (ph == l);
        chk("clkout",  CLKOUT,  e_clk);
        chk("tick",    TICK,    e_tick);
        chk("div_err", DIV_ERR, e_err);
        chk("busy",    BUSY,    e_busy);
        chk("div_ack", DIV_ACK, e_ack);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        ph     = 0;
        dm     = 16;
        ACLR_L = 1'b0;
        EN     = 1'b0;
        DIV_LD = 1'b0;
        DIV_IN = '0;

        // reset state
        repeat (2) @(posedge CLKIN);
        #1;
        chk("rst_clkout", CLKOUT,  1'b0);
        chk("rst_tick",   TICK,    1'b0);
        chk("rst_busy",   BUSY,    1'b0);
        chk("rst_ack",    DIV_ACK, 1'b0);
        chk("rst_err",    DIV_ERR, 1'b0);

        // default divide-by-16: rise on edge 8, fall on edge 16
        ACLR_L = 1'b1;
        EN     = 1'b1;
        repeat (40) step(1'b0, 1'b0, 1'b0);

        // illegal divisors 1 then 0: error pulses, nothing pending
        DIV_LD = 1'b1; DIV_IN = 16'd1;
        step(1'b1, 1'b0, 1'b0);
        DIV_IN = 16'd0;
        step(1'b1, 1'b0, 1'b0);
        DIV_LD = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // load 4 at cnt=3, applied at the wrap
        while (ph != 3) step(1'b0, 1'b0, 1'b0);
        DIV_LD = 1'b1; DIV_IN = 16'd4;
        step(1'b0, 1'b1, 1'b0);
        DIV_LD = 1'b0;
        while (ph != dm - 1) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        dm = 4;
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // load 5: odd honoured only with CLKDIVS_ODD_EN
        DIV_LD = 1'b1; DIV_IN = 16'd5;
        step(1'b0, 1'b1, 1'b0);
        DIV_LD = 1'b0;
        while (ph != dm - 1) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
`ifdef CLKDIVS_ODD_EN
        dm = 5;
`else
        dm = 4;
`endif
        repeat (10) step(1'b0, 1'b0, 1'b0);

        // freeze in the high phase, load 6 while frozen
        while (ph != dm - dm / 2) step(1'b0, 1'b0, 1'b0);
        EN = 1'b0;
        repeat (7) step(1'b0, 1'b0, 1'b0);
        DIV_LD = 1'b1; DIV_IN = 16'd6;
        step(1'b0, 1'b1, 1'b0);
        DIV_LD = 1'b0;
        ph = 0;
        dm = 6;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        EN = 1'b1;
        repeat (18) step(1'b0, 1'b0, 1'b0);

        // asynchronous reset while a divisor is pending
        DIV_LD = 1'b1; DIV_IN = 16'd10;
        step(1'b0, 1'b1, 1'b0);
        DIV_LD = 1'b0;
        ACLR_L = 1'b0;
        #1;
        chk("aclr_busy",   BUSY,    1'b0);
        chk("aclr_clkout", CLKOUT,  1'b0);
        chk("aclr_ack",    DIV_ACK, 1'b0);
        @(posedge CLKIN);
        #1;
        chk("aclr_hold_busy", BUSY,   1'b0);
        chk("aclr_hold_clk",  CLKOUT, 1'b0);
        ACLR_L = 1'b1;
        ph = 0;
        dm = 16;
        repeat (20) step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clkdivs_prog.md
# clkdivs_prog

Runtime-programmable clock divider for the LED system's timing tree; the parametrised successor of the fixed divide-by-16 prescaler. It produces a registered divided clock CLKOUT and a single-cycle TICK strobe from CLKIN. The divisor is reloaded through a strobe/acknowledge handshake and takes effect only at a period boundary, so CLKOUT never glitches. It feeds LED PWM and scan logic that needs software-selectable rates.

## Interface
- W, 16: divisor and counter width in bits.
- DEF_DIV, 16: divisor after reset; must satisfy 2 ≤ DEF_DIV < 2^W.
- CLKIN  in  1  system clock; all logic on rising edge.
- ACLR_L  in  1  asynchronous active-low reset.
- EN  in  1  count enable; low freezes the counter and CLKOUT.
- DIV_LD  in  1  one-cycle strobe; DIV_IN is captured on this edge.
- DIV_IN  in  W  requested divisor D.
- DIV_ACK  out  1  one-cycle pulse on the edge the new divisor becomes active.
- DIV_ERR  out  1  one-cycle pulse when a captured DIV_IN is below 2.
- BUSY  out  1  a pending divisor is waiting for a boundary.
- CLKOUT  out  1  divided clock.
- TICK  out  1  high for one cycle in the cycle CLKOUT goes from 0 to 1.

## Operation
- Registers:
  - d_act: active divisor (W bits).
  - d_pend: pending divisor (W bits).
  - pend: pending flag.
  - cnt: counter (W bits).
  - CLKOUT, TICK, DIV_ACK, DIV_ERR.
- Reset values:
  - cnt=0, d_act=DEF_DIV, pend=0.
  - CLKOUT=0, TICK=0, DIV_ACK=0, DIV_ERR=0, BUSY=0.
- Phases: the low phase is L = D − H; the high phase H is set by the Configuration section.
- Each edge with EN=1:
  - If cnt == d_act−1: cnt←0 and CLKOUT←0 (wrap / period boundary).
  - Else: cnt←cnt+1.
  - If cnt == L−1: CLKOUT←1 and TICK←1 on the same edge.
- With EN=0, cnt and CLKOUT hold; TICK is 0.
- DIV_LD with DIV_IN ≥ 2: d_pend←DIV_IN and pend←1.
- DIV_LD with DIV_IN < 2: the value is discarded, DIV_ERR pulses on the next cycle, and pend is unchanged.
- DIV_LD while pend=1 overwrites d_pend (last write wins). Only one DIV_ACK results.
- Applying a pending divisor:
  - With EN=1, it is applied at the first wrap strictly after the capture edge: d_act←d_pend, pend←0, DIV_ACK←1. The wrap itself behaves normally (cnt←0, CLKOUT←0).
  - With EN=0, it is applied on the first edge after capture: d_act←d_pend, cnt←0, CLKOUT←0, pend←0, DIV_ACK←1.
- DIV_LD on the same edge as a wrap: the old pending value (if any) is applied, the new value becomes pending, and BUSY stays 1.
- BUSY = pend, driven directly from the register.

## Timing
- Every output is registered; no combinational path runs from inputs to outputs.
- Period: D enabled cycles, with CLKOUT low for L cycles and then high for H cycles.
- First rise after reset: CLKOUT and TICK go high on the L-th enabled edge.
- Default D=16: CLKOUT rises on edge 8 and falls on edge 16. This is identical to the legacy divide-by-16 block.
- DIV_ERR: asserted exactly 1 cycle after the DIV_LD edge.
- DIV_ACK: asserted on the boundary edge and high for exactly 1 cycle.
- ACLR_L low at any time: all registers return to reset values immediately, any pending divisor is dropped, and the next period starts from cnt=0.
- D = 2^W − 1 is legal. cnt never exceeds d_act−1, so it never wraps on its own width.

## Configuration
- CLKDIVS_ODD_EN defined:
  - Odd D is used as-is: H = (D−1)/2, L = (D+1)/2.
  - Example: D=5 gives CLKOUT low 3 cycles, high 2.
- CLKDIVS_ODD_EN undefined:
  - The LSB of DIV_IN is cleared at capture, so odd D behaves as D−1.
  - An odd DEF_DIV is also treated as DEF_DIV−1.
  - H = L = D/2, so CLKOUT is always 50% duty.
  - A request of D=3 is stored as 2 and is not an error.

## Test plan
- Reset, EN=1, defaults → CLKOUT rises on edge 8 and falls on edge 16, period 16; TICK pulses on edges 8, 24, 40; BUSY, DIV_ACK and DIV_ERR stay 0.
- DIV_LD with DIV_IN=4 at cnt=3 → BUSY=1 until the wrap at cnt=15; DIV_ACK is a single pulse on that edge; the following periods are 4 cycles with CLKOUT 2 low, 2 high; no CLKOUT pulse shorter than 2 cycles.
- DIV_IN=5 → with CLKDIVS_ODD_EN, period 5 with 3 low, 2 high; without it, period 4 with 2 low, 2 high.
- DIV_LD with DIV_IN=1, then DIV_IN=0 → DIV_ERR pulses 1 cycle after each, d_act remains 16, BUSY stays 0.
- EN=0 for 10 cycles mid-high-phase → CLKOUT and cnt hold and no TICK occurs; DIV_LD with DIV_IN=6 during this window gives DIV_ACK on the next edge with CLKOUT=0 and cnt=0; with EN=1 afterwards, period is 6.
- ACLR_L pulsed low while BUSY=1 → BUSY=0, CLKOUT=0, d_act=16 immediately, no DIV_ACK, and the first rise comes 8 edges after release.
